rr_decoder_arbiter: RTL



---
 rtl/rr_decoder_arbiter_if.sv | 25 ++
 rtl/rr_decoder_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master: arbiter side (drives grants); slave: requester side (drives req).
interface rr_decoder_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with hold-timeout preemption.
// Ports: clk, rst (async high), bus (req in; gnt/gnt_idx/gnt_valid/preempt out).
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  rr_decoder_arbiter_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            preempt_q, preempt_d;
  logic [3:0]      gnt_q, gnt_d;

  logic [1:0]      cand;
  logic [1:0]      win_idx;
  logic            win_found;
  logic [3:0]      others;

  // Rotating search starting just past the last winner; offset 4
  // wraps back onto last itself so a lone repeat requester still wins.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign others = bus.req & ~(4'b0001 << gnt_idx_q);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d     = GRANT;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          last_d      = win_idx;
          hold_cnt_d  = CW'(1);
        end else begin
          state_d     = IDLE;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.req[gnt_idx_q]) begin
          state_d     = GAP;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end else if (hold_cnt_q == CW'(MAX_HOLD) && |others) begin
          state_d     = GAP;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
        end else if (hold_cnt_q != CW'(MAX_HOLD)) begin
          hold_cnt_d  = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
    gnt_d = gnt_valid_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      last_q      <= 2'd3;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      gnt_q       <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule
